// File: rtl/famiclone_detector.sv
// famiclone_detector: grounds CIRAM lines after reset, then classifies the host by comparing PPU A13 with /A13 on read cycles
module famiclone_detector #(
  parameter int INIT_CYCLES        = 15,
  parameter int INIT_BITS          = 4,
  parameter int SAMPLES_PER_PHASE  = 3,
  parameter int SAMPLE_BITS        = 2,
  parameter int MISMATCH_THRESHOLD = 1,
  parameter int TIMEOUT_CYCLES     = 4096,
  parameter int TIMEOUT_BITS       = 13
) (
  input  logic                 m2,
  input  logic                 reset,
  input  logic                 ppu_rd_in,
  input  logic                 ppu_a13,
  input  logic                 ppu_not_a13,
  output logic                 init_finished,
  output logic                 ground_en,
  output logic [1:0]           ciram_mode,
  output logic                 new_dendy,
  output logic                 detect_done,
  output logic                 timeout,
  output logic [SAMPLE_BITS:0] mismatch_count
);
  typedef enum logic [1:0] {INIT, SAMPLE, DONE} state_t;
  localparam logic [INIT_BITS-1:0]    INIT_LOAD = INIT_BITS'(INIT_CYCLES);
  localparam logic [SAMPLE_BITS-1:0]  SPP       = SAMPLE_BITS'(SAMPLES_PER_PHASE);
  localparam logic [SAMPLE_BITS:0]    THR       = (SAMPLE_BITS+1)'(MISMATCH_THRESHOLD);
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST  = TIMEOUT_BITS'(TIMEOUT_CYCLES-1);
  state_t                  state, state_n;
  logic [INIT_BITS-1:0]    init_cnt, init_n;
  logic [SAMPLE_BITS-1:0]  lo_cnt, lo_n, hi_cnt, hi_n;
  logic [TIMEOUT_BITS-1:0] tmo_cnt, tmo_n;
  logic [SAMPLE_BITS:0]    mm_n;
  logic                    nd_n, to_n, open_c, done_c;
  logic                    rd_s1, rd_s2, rd_prev, rd_fall;
  logic                    a13_s1, a13_s2, na_s1, na_s2;
  assign init_finished = state != INIT;
  assign ground_en     = state == INIT;
  assign detect_done   = state == DONE;
  assign ciram_mode    = ground_en ? 2'b00 : new_dendy ? 2'b01 : 2'b10;
  assign open_c        = (lo_cnt < SPP) && (hi_cnt < SPP);
  always_comb begin
    state_n = state;
    init_n  = init_cnt;
    lo_n    = lo_cnt;
    hi_n    = hi_cnt;
    tmo_n   = tmo_cnt;
    mm_n    = mismatch_count;
    nd_n    = new_dendy;
    to_n    = timeout;
    done_c  = 1'b0;
    if (state == INIT) begin
      init_n  = init_cnt - 1'b1;
      state_n = (init_cnt == INIT_BITS'(1)) ? SAMPLE : INIT;
    end else if (state == SAMPLE) begin
      tmo_n = tmo_cnt + 1'b1;
      if (rd_fall) begin
        mm_n = (open_c && (a13_s2 == na_s2) && (mismatch_count < THR)) ? mismatch_count + 1'b1 : mismatch_count;
        lo_n = (!a13_s2 && lo_cnt < SPP) ? lo_cnt + 1'b1 : lo_cnt;
        hi_n = (a13_s2 && hi_cnt < SPP) ? hi_cnt + 1'b1 : hi_cnt;
        nd_n = new_dendy | (mm_n == THR);
      end
      done_c  = (lo_n == SPP) && (hi_n == SPP);
      to_n    = !done_c && (tmo_n == TMO_LAST);
      state_n = (done_c || to_n) ? DONE : SAMPLE;
    end
  end
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state          <= INIT;
      init_cnt       <= INIT_LOAD;
      lo_cnt         <= '0;
      hi_cnt         <= '0;
      tmo_cnt        <= '0;
      mismatch_count <= '0;
      new_dendy      <= 1'b0;
      timeout        <= 1'b0;
      {rd_s1, rd_s2, rd_prev, rd_fall} <= 4'b1110;
      {a13_s1, a13_s2, na_s1, na_s2}   <= 4'b0011;
    end else begin
      state          <= state_n;
      init_cnt       <= init_n;
      lo_cnt         <= lo_n;
      hi_cnt         <= hi_n;
      tmo_cnt        <= tmo_n;
      mismatch_count <= mm_n;
      new_dendy      <= nd_n;
      timeout        <= to_n;
      rd_s1          <= ppu_rd_in;
      rd_s2          <= rd_s1;
      rd_prev        <= rd_s2;
      rd_fall        <= rd_prev & ~rd_s2;
      a13_s1         <= ppu_a13;
      a13_s2         <= a13_s1;
      na_s1          <= ppu_not_a13;
      na_s2          <= na_s1;
    end
  end
endmodule

// File: tb/tb_famiclone_detector.sv
// tb_famiclone_detector: scoreboard bench; expected classifications queued at stimulus, compared when detect_done rises
module tb_famiclone_detector;
  logic       m2 = 0, reset = 1, ppu_rd_in = 1, ppu_a13 = 0, ppu_not_a13 = 1;
  logic       init_finished, ground_en, new_dendy, detect_done, timeout;
  logic [1:0] ciram_mode;
  logic [2:0] mismatch_count;
  int         errors = 0, checks = 0, cyc = 0;
  typedef struct {int cyc; int nd; int to; int mm; int mode;} exp_t;
  exp_t       sb[$];
  logic       nd3;
  famiclone_detector dut (
    .m2(m2), .reset(reset), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13), .ppu_not_a13(ppu_not_a13),
    .init_finished(init_finished), .ground_en(ground_en), .ciram_mode(ciram_mode),
    .new_dendy(new_dendy), .detect_done(detect_done), .timeout(timeout), .mismatch_count(mismatch_count)
  );
  always #5 m2 = ~m2;
  always @(posedge m2 or posedge reset) cyc <= reset ? 0 : cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge m2);
    #1;
  endtask
  task automatic do_reset;
    @(posedge m2);
    #1;
    reset = 1;
    ppu_rd_in = 1;
    ppu_a13 = 0;
    ppu_not_a13 = 1;
    tick;
    reset = 0;
    repeat (15) tick;
  endtask
  task automatic rd_cycle(input logic a, input logic na, output logic nd_mid);
    ppu_a13 = a;
    ppu_not_a13 = na;
    ppu_rd_in = 0;
    tick;
    tick;
    ppu_rd_in = 1;
    tick;
    nd_mid = new_dendy;
    tick;
  endtask
  task automatic run_seq(input logic lo_na, input logic hi_na, input int nd, input int mm, output logic first_nd3);
    logic d;
    rd_cycle(1'b0, lo_na, first_nd3);
    rd_cycle(1'b0, lo_na, d);
    rd_cycle(1'b0, lo_na, d);
    rd_cycle(1'b1, hi_na, d);
    rd_cycle(1'b1, hi_na, d);
    sb.push_back('{cyc + 4, nd, 0, mm, nd ? 1 : 2});
    rd_cycle(1'b1, hi_na, d);
  endtask
  task automatic wait_done;
    exp_t e;
    int n = 0;
    while (!detect_done && n < 5000) begin
      tick;
      n++;
    end
    check("done_seen", detect_done, 1);
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("done_cycle", cyc, e.cyc);
      check("new_dendy", new_dendy, e.nd);
      check("timeout", timeout, e.to);
      check("mismatch_count", mismatch_count, e.mm);
      check("ciram_mode", ciram_mode, e.mode);
      check("init_finished", init_finished, 1);
    end
  endtask
  initial begin
    #2;
    check("rst_ground_en", ground_en, 1);
    check("rst_init_finished", init_finished, 0);
    check("rst_ciram_mode", ciram_mode, 0);
    check("rst_new_dendy", new_dendy, 0);
    check("rst_done", detect_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_mm", mismatch_count, 0);
    @(posedge m2);
    #1;
    reset = 0;
    for (int i = 1; i <= 16; i++) begin
      tick;
      check("init_ground_en", ground_en, cyc < 15);
      check("init_finished", init_finished, cyc >= 15);
      check("init_mode", ciram_mode, cyc < 15 ? 0 : 2);
    end
    do_reset;
    run_seq(1'b1, 1'b0, 0, 0, nd3);
    wait_done;
    do_reset;
    ppu_not_a13 = 0;
    run_seq(1'b0, 1'b0, 1, 1, nd3);
    check("fam_nd_edge3", nd3, 0);
    wait_done;
    do_reset;
    run_seq(1'b1, 1'b1, 0, 0, nd3);
    wait_done;
    do_reset;
    sb.push_back('{15 + 4095, 0, 1, 0, 2});
    wait_done;
    do_reset;
    rd_cycle(1'b0, 1'b1, nd3);
    rd_cycle(1'b0, 1'b1, nd3);
    rd_cycle(1'b0, 1'b1, nd3);
    rd_cycle(1'b1, 1'b0, nd3);
    rd_cycle(1'b1, 1'b0, nd3);
    for (int i = 0; i < 5000 && cyc < 4106; i++) tick;
    check("pre_edge_done", detect_done, 0);
    sb.push_back('{4110, 0, 0, 0, 2});
    rd_cycle(1'b1, 1'b0, nd3);
    wait_done;
    do_reset;
    ppu_not_a13 = 0;
    rd_cycle(1'b0, 1'b0, nd3);
    check("mid_nd_set", new_dendy, 1);
    check("mid_mode_hiz", ciram_mode, 1);
    check("mid_mm", mismatch_count, 1);
    #2;
    reset = 1;
    #1;
    check("arst_ground_en", ground_en, 1);
    check("arst_init_finished", init_finished, 0);
    check("arst_mode", ciram_mode, 0);
    check("arst_nd", new_dendy, 0);
    check("arst_mm", mismatch_count, 0);
    check("arst_done", detect_done, 0);
    check("arst_timeout", timeout, 0);
    do_reset;
    run_seq(1'b1, 1'b0, 0, 0, nd3);
    wait_done;
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
